// File: rtl/wb_commit.sv
// Writeback/commit stage: selects the register-file write value, performs the CSR
// write handshake with stall and timeout, and tracks forwarding, instret and retire PC.
module wb_commit #(
  parameter int CSR_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wb_valid,
  input  logic [31:0] dmem_dataout,
  input  logic [31:0] result,
  input  logic [4:0]  rd,
  input  logic [2:0]  wb_src,
  input  logic [31:0] pc,
  input  logic [15:0] csr_op,
  input  logic [31:0] csr_dataout,
  input  logic [31:0] csr_result,
  input  logic        csr_wr_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        csr_wr_valid,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic        wb_stall,
  output logic        csr_err,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [63:0] instret,
  output logic [31:0] retire_pc
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(CSR_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [31:0]      wdata;
  logic             needs_csr, timed_out, abort, commit, src_writes;
  logic             unused_csr_rsvd;

  function automatic logic [31:0] sel_wdata(input logic [2:0]  src,
                                            input logic [31:0] res,
                                            input logic [31:0] dmem,
                                            input logic [31:0] ipc,
                                            input logic [31:0] csr_old);
    case (src)
      3'd1:    sel_wdata = res;
      3'd2:    sel_wdata = dmem;
      3'd3:    sel_wdata = ipc + 32'd4;
      3'd4:    sel_wdata = csr_old;
      default: sel_wdata = 32'd0;
    endcase
  endfunction

  assign unused_csr_rsvd = ^csr_op[3:1];

  always_comb begin
    wdata      = sel_wdata(wb_src, result, dmem_dataout, pc, csr_dataout);
    src_writes = (wb_src >= 3'd1) && (wb_src <= 3'd4);
    needs_csr  = wb_valid & csr_op[0];
    // wait_cnt reaches CSR_TIMEOUT exactly on the (CSR_TIMEOUT+1)th cycle of a stalled instruction
    timed_out  = (CSR_TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT);
    abort      = needs_csr & ~csr_wr_ready & timed_out;
    commit     = wb_valid & (~needs_csr | csr_wr_ready | abort);

    csr_wr_valid = needs_csr & ~abort;
    csr_wr_addr  = csr_op[15:4];
    csr_wr_data  = csr_result;
    wb_stall     = wb_valid & ~commit;
    rf_we        = commit & src_writes & (rd != 5'd0);
    rf_waddr     = rd;
    rf_wdata     = wdata;
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (wb_stall) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end else begin
          wait_cnt_nxt = '0;
        end
      end
      WAIT: begin
        if (wb_stall) begin
          wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
        end else begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      csr_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      csr_err  <= abort;
    end
  end

  // Commit-side state: forwarding latch, retire counter and last retired PC
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fwd_valid <= 1'b0;
      fwd_rd    <= 5'd0;
      fwd_data  <= 32'd0;
      instret   <= 64'd0;
      retire_pc <= 32'd0;
    end else if (commit) begin
      instret   <= instret + 64'd1;
      retire_pc <= pc;
      fwd_valid <= rf_we;
      if (rf_we) begin
        fwd_rd   <= rd;
        fwd_data <= wdata;
      end
    end else if (!wb_valid) begin
      fwd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_wb_commit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        wb_valid;
  logic [31:0] dmem_dataout, result, pc, csr_dataout, csr_result;
  logic [4:0]  rd;
  logic [2:0]  wb_src;
  logic [15:0] csr_op;
  logic        csr_wr_ready;
  logic        rf_we, csr_wr_valid, wb_stall, csr_err, fwd_valid;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, csr_wr_data, fwd_data, retire_pc;
  logic [11:0] csr_wr_addr;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;

  wb_commit #(.CSR_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .wb_valid(wb_valid), .dmem_dataout(dmem_dataout),
    .result(result), .rd(rd), .wb_src(wb_src), .pc(pc), .csr_op(csr_op),
    .csr_dataout(csr_dataout), .csr_result(csr_result), .csr_wr_ready(csr_wr_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .csr_wr_valid(csr_wr_valid),
    .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data), .wb_stall(wb_stall),
    .csr_err(csr_err), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret), .retire_pc(retire_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: stalled-cycle count of the current instruction plus architectural state
  int          m_wait;
  logic        m_err, m_fv;
  logic [4:0]  m_frd;
  logic [31:0] m_fdata, m_rpc;
  logic [63:0] m_instret;
  logic        e_needs, e_abort, e_commit, e_stall, e_csrv, e_we;
  logic [31:0] e_wdata;

  always_comb begin
    case (wb_src)
      3'd1:    e_wdata = result;
      3'd2:    e_wdata = dmem_dataout;
      3'd3:    e_wdata = pc + 32'd4;
      3'd4:    e_wdata = csr_dataout;
      default: e_wdata = 32'd0;
    endcase
    e_needs  = wb_valid && csr_op[0];
    e_abort  = e_needs && !csr_wr_ready && (TO != 0) && (m_wait == TO);
    e_commit = wb_valid && (!e_needs || csr_wr_ready || e_abort);
    e_stall  = wb_valid && !e_commit;
    e_csrv   = e_needs && !e_abort;
    e_we     = e_commit && (wb_src inside {3'd1, 3'd2, 3'd3, 3'd4}) && (rd != 5'd0);
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_wait <= 0; m_err <= 1'b0; m_fv <= 1'b0; m_frd <= 5'd0;
      m_fdata <= 32'd0; m_rpc <= 32'd0; m_instret <= 64'd0;
    end else begin
      m_wait <= e_stall ? m_wait + 1 : 0;
      m_err  <= e_abort;
      if (e_commit) begin
        m_instret <= m_instret + 64'd1;
        m_rpc     <= pc;
        m_fv      <= e_we;
        if (e_we) begin
          m_frd   <= rd;
          m_fdata <= e_wdata;
        end
      end else if (!wb_valid) begin
        m_fv <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_waddr", rf_waddr, rd);
      chk("rf_wdata", rf_wdata, e_wdata);
    end
    chk("csr_wr_valid", csr_wr_valid, e_csrv);
    if (e_csrv) begin
      chk("csr_wr_addr", csr_wr_addr, csr_op[15:4]);
      chk("csr_wr_data", csr_wr_data, csr_result);
    end
    chk("wb_stall", wb_stall, e_stall);
    chk("csr_err", csr_err, m_err);
    chk("fwd_valid", fwd_valid, m_fv);
    chk("fwd_rd", fwd_rd, m_frd);
    chk("fwd_data", fwd_data, m_fdata);
    chk("instret", instret, m_instret);
    chk("retire_pc", retire_pc, m_rpc);
  end

  task automatic issue(input logic v, input logic [2:0] src, input logic [4:0] d,
                       input logic [31:0] p, input logic [31:0] res, input logic [31:0] dm,
                       input logic [15:0] op, input logic [31:0] cdo, input logic [31:0] cres,
                       input logic rdy);
    wb_valid = v; wb_src = src; rd = d; pc = p; result = res; dmem_dataout = dm;
    csr_op = op; csr_dataout = cdo; csr_result = cres; csr_wr_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic        stalled;
  logic [31:0] r;

  initial begin
    nrst = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instret", instret, 64'd0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    chk("rst_csr_err", csr_err, 1'b0);
    chk("rst_retire_pc", retire_pc, 32'd0);
    nrst = 1'b1;

    // ALU write to x5
    issue(1, 1, 5, 32'h100, 32'h1234, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu_we", rf_we, 1'b1); chk("alu_waddr", rf_waddr, 5'd5); chk("alu_wdata", rf_wdata, 32'h1234);
    next_cycle();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu_fwd_valid", fwd_valid, 1'b1); chk("alu_fwd_rd", fwd_rd, 5'd5);
    chk("alu_fwd_data", fwd_data, 32'h1234); chk("alu_instret", instret, 64'd1);
    next_cycle();

    // Load to x0 then link with wrapping PC
    issue(1, 2, 0, 32'h104, 0, 32'hDEAD, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0_we", rf_we, 1'b0);
    next_cycle();
    issue(1, 3, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("link_we", rf_we, 1'b1); chk("link_wdata", rf_wdata, 32'd0); chk("x0_instret", instret, 64'd2);
    next_cycle();

    // CSR write acknowledged after three stalled cycles
    issue(1, 4, 7, 32'h200, 0, 0, 16'h3001, 32'h8, 32'h88, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("csr_stall", wb_stall, 1'b1);
      chk("csr_req", csr_wr_valid, 1'b1);
      next_cycle();
    end
    csr_wr_ready = 1'b1;
    @(negedge clk);
    chk("csr_nostall", wb_stall, 1'b0); chk("csr_addr", csr_wr_addr, 12'h300);
    chk("csr_data", csr_wr_data, 32'h88); chk("csr_rdval", rf_wdata, 32'h8);
    chk("csr_instret_before", instret, 64'd3);
    next_cycle();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("csr_instret_after", instret, 64'd4);
    next_cycle();

    // CSR write that never gets ready: aborted on the fifth cycle
    issue(1, 4, 9, 32'h300, 0, 0, 16'h3401, 32'h55, 32'h66, 0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_stall", wb_stall, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk("to_commit_stall", wb_stall, 1'b0); chk("to_csr_valid", csr_wr_valid, 1'b0);
    chk("to_rf_we", rf_we, 1'b1); chk("to_err_early", csr_err, 1'b0);
    next_cycle();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("to_err_pulse", csr_err, 1'b1); chk("to_instret", instret, 64'd5); chk("to_fwd_data", fwd_data, 32'h55);
    next_cycle();
    @(negedge clk);
    chk("to_err_clear", csr_err, 1'b0);
    next_cycle();

    // Asynchronous reset while a CSR write is waiting
    issue(1, 4, 3, 32'h400, 0, 0, 16'h3011, 32'h1, 32'h2, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rw_stall", wb_stall, 1'b1);
      next_cycle();
    end
    #1;
    nrst = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rw_instret", instret, 64'd0); chk("rw_retire_pc", retire_pc, 32'd0);
    chk("rw_fwd_valid", fwd_valid, 1'b0); chk("rw_fwd_rd", fwd_rd, 5'd0);
    chk("rw_fwd_data", fwd_data, 32'd0); chk("rw_csr_err", csr_err, 1'b0);
    chk("rw_csr_valid", csr_wr_valid, 1'b0); chk("rw_stall0", wb_stall, 1'b0); chk("rw_rf_we", rf_we, 1'b0);
    next_cycle();
    nrst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rw_no_req", csr_wr_valid, 1'b0);
      next_cycle();
    end
    issue(1, 0, 0, 32'h500, 0, 0, 16'h3051, 0, 32'h9, 1);
    @(negedge clk);
    chk("rw_new_req", csr_wr_valid, 1'b1); chk("rw_new_stall", wb_stall, 1'b0);
    next_cycle();

    // Ten back-to-back ALU instructions from a fresh reset
    nrst = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    nrst = 1'b1;
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      issue(1, 1, 5'(i + 1), 32'h1000 + 32'(4 * i), 32'(i * 3 + 7), 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("stream_stall", wb_stall, 1'b0);
      next_cycle();
    end
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stream_instret", instret, 64'd10); chk("stream_pc", retire_pc, 32'h1024);
    chk("stream_fwd_rd", fwd_rd, 5'd10); chk("stream_fwd_data", fwd_data, 32'd34);
    next_cycle();

    // Randomized traffic; inputs are held while the model says the stage is stalled
    stalled = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!stalled) begin
        r = $urandom;
        issue(r[1:0] != 2'b00, 3'($urandom_range(0, 7)), r[6:2], $urandom, $urandom, $urandom,
              {r[18:7], r[21:19], (r[23:22] == 2'b00)}, $urandom, $urandom, r[24] | r[25]);
      end else begin
        csr_wr_ready = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      stalled = e_stall;
      next_cycle();
    end
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
